// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if
//   Start/ready/done handshake and data bundle for the BCD-to-binary converter.
//   It carries the same handshake shape as the binary-to-BCD block, so the two
//   can be chained.
//
//   Signals:
//     start        conversion request (sampled only while ready=1)
//     BCD_value    DIGITS packed BCD digits, [DIGITS-1] is the most significant
//     ready        converter idle and able to accept start
//     done         one-cycle pulse, result outputs valid
//     binary_value conversion result, held until the next conversion completes
//     overflow     decimal value exceeded 2^BIN_WIDTH-1
//     digit_error  at least one input digit was greater than 9
//
//   Modports:
//     master  requester side (drives start/BCD_value)
//     slave   converter side
interface bcd_to_binary_if #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned BIN_WIDTH = 26
);
  logic                 start;
  logic [3:0]           BCD_value [DIGITS-1:0];
  logic                 ready;
  logic                 done;
  logic [BIN_WIDTH-1:0] binary_value;
  logic                 overflow;
  logic                 digit_error;

  modport master (
    output start, BCD_value,
    input  ready, done, binary_value, overflow, digit_error
  );

  modport slave (
    input  start, BCD_value,
    output ready, done, binary_value, overflow, digit_error
  );
endinterface

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
//   Iterative converter from DIGITS packed BCD digits to a BIN_WIDTH-bit
//   unsigned value. One digit is consumed per clock, most significant first,
//   using acc = acc*10 + digit. A conversion takes DIGITS+2 edges from the
//   accepting edge until ready is high again.
//
//   Ports:
//     clk   system clock, all state changes on the rising edge
//     rstN  asynchronous active-low reset
//     bus   bcd_to_binary_if.slave: start/BCD_value in; ready, done,
//           binary_value, overflow, digit_error out (all registered)
//
//   Result rules: a digit above 9 forces binary_value=0, digit_error=1,
//   overflow=0; otherwise a value above 2^BIN_WIDTH-1 forces all ones with
//   overflow=1; otherwise the exact value. Results hold until the next
//   conversion completes (they are not cleared at start).
module bcd_to_binary #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned BIN_WIDTH = 26
) (
  input  logic           clk,
  input  logic           rstN,
  bcd_to_binary_if.slave bus
);

  // Four guard bits: while no overflow has been flagged, acc < 2^BIN_WIDTH,
  // so acc*10 + 15 stays below 2^(BIN_WIDTH+4) and a single step never wraps.
  localparam int unsigned ACC_W = BIN_WIDTH + 4;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t               state;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           shreg [DIGITS-1:0];
  logic                 ovf;
  logic                 err;

  logic                 ready_q;
  logic                 done_q;
  logic [BIN_WIDTH-1:0] value_q;
  logic                 overflow_q;
  logic                 digit_error_q;

  // Next-step values for the CONVERT state.
  logic [3:0]           msd;
  logic [ACC_W-1:0]     acc_x10;
  logic [ACC_W-1:0]     step_acc;
  logic                 step_err;
  logic                 step_ovf;

  always_comb begin
    msd      = shreg[DIGITS-1];
    acc_x10  = (acc << 3) + (acc << 1);
    // Once overflow is flagged the accumulator is frozen; its value is
    // discarded anyway and freezing keeps the multiply from wrapping.
    step_acc = ovf ? acc : (acc_x10 + ACC_W'(msd));
    step_err = err | (msd > 4'd9);
    step_ovf = ovf | (|step_acc[ACC_W-1:BIN_WIDTH]);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      value_q       <= '0;
      overflow_q    <= 1'b0;
      digit_error_q <= 1'b0;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      err           <= 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        shreg[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
              shreg[i] <= bus.BCD_value[i];
            end
            acc     <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            cnt     <= CNT_W'(DIGITS - 1);
            ready_q <= 1'b0;
            state   <= CONVERT;
          end
        end

        CONVERT: begin
          acc <= step_acc;
          err <= step_err;
          ovf <= step_ovf;
          for (int unsigned i = DIGITS - 1; i > 0; i--) begin
            shreg[i] <= shreg[i-1];
          end
          shreg[0] <= '0;

          if (cnt == '0) begin
            // Results use this step's flags, not the registered sticky ones,
            // so the final digit is included.
            if (step_err) begin
              value_q       <= '0;
              overflow_q    <= 1'b0;
              digit_error_q <= 1'b1;
            end else if (step_ovf) begin
              value_q       <= '1;
              overflow_q    <= 1'b1;
              digit_error_q <= 1'b0;
            end else begin
              value_q       <= step_acc[BIN_WIDTH-1:0];
              overflow_q    <= 1'b0;
              digit_error_q <= 1'b0;
            end
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready        = ready_q;
  assign bus.done         = done_q;
  assign bus.binary_value = value_q;
  assign bus.overflow     = overflow_q;
  assign bus.digit_error  = digit_error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary
//   Directed and randomized checks of bcd_to_binary against a positional
//   decimal reference model (8 digits, 26-bit result).
module tb_bcd_to_binary;

  localparam int unsigned DIGITS    = 8;
  localparam int unsigned BIN_WIDTH = 26;
  localparam longint unsigned MAXV  = 64'd67108863;

  logic clk;
  logic rstN;
  int   checks;
  int   failures;

  bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) bus ();

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bcd(input logic [31:0] w);
    for (int i = 0; i < DIGITS; i++) bus.BCD_value[i] = w[4*i +: 4];
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] w;
    int unsigned t;
    w = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      w[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return w;
  endfunction

  // Value = sum of digit * 10^position; result rules applied afterwards.
  task automatic model(input logic [31:0] w, output logic [25:0] bv,
                       output logic of, output logic de);
    longint unsigned v, p;
    logic [3:0] d;
    v = 0;
    p = 1;
    de = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = w[4*i +: 4];
      if (d > 4'd9) de = 1'b1;
      v = v + longint'(d) * p;
      p = p * 10;
    end
    if (de) begin
      bv = '0; of = 1'b0;
    end else if (v > MAXV) begin
      bv = '1; of = 1'b1;
    end else begin
      bv = v[25:0]; of = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 2))
      0:       return to_bcd($urandom_range(0, 67108863));
      1:       return to_bcd($urandom_range(67108864, 99999999));
      default: return $urandom;
    endcase
  endfunction

  // One conversion from idle: checks ready drop, done latency, results,
  // single-cycle done and ready return. BCD_value is scrambled after the
  // start edge to confirm the captured digits are used.
  task automatic do_conv(input logic [31:0] w, input string tag);
    logic [25:0] ebv;
    logic        eof, ede;
    int          n;
    model(w, ebv, eof, ede);
    @(negedge clk);
    set_bcd(w);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    set_bcd($urandom);
    chk({tag, "_ready_low"}, 64'(bus.ready), 64'd0);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) break;
    end
    chk({tag, "_latency"}, 64'(n), 64'd8);
    chk({tag, "_value"}, 64'(bus.binary_value), 64'(ebv));
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'(eof));
    chk({tag, "_digit_error"}, 64'(bus.digit_error), 64'(ede));
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, 64'(bus.done), 64'd0);
    chk({tag, "_ready_back"}, 64'(bus.ready), 64'd1);
  endtask

  initial begin
    logic [31:0] words [40];
    logic [25:0] ebv;
    logic        eof, ede;
    int          pulses;
    int unsigned v;

    checks    = 0;
    failures  = 0;
    rstN      = 1'b1;
    bus.start = 1'b0;
    set_bcd('0);

    // Reset state
    #2 rstN = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_value", 64'(bus.binary_value), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_digit_error", 64'(bus.digit_error), 64'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Basic and in-range values
    do_conv(32'h00000162, "t1_162");
    do_conv(32'h00043210, "t2_43210");
    do_conv(32'h67108863, "t2_max");
    chk("t2_max_exact", 64'(bus.binary_value), 64'h3FFFFFF);

    // Overflow and recovery
    do_conv(32'h67108864, "t3_max_plus1");
    chk("t3_ovf_flag", 64'(bus.overflow), 64'd1);
    do_conv(32'h99999999, "t3_all9");
    do_conv(32'h00000000, "t3_zero");
    chk("t3_zero_ovf", 64'(bus.overflow), 64'd0);

    // Digit errors, error priority over overflow
    do_conv(32'h0012A456, "t4_err");
    chk("t4_err_flag", 64'(bus.digit_error), 64'd1);
    do_conv(32'h9F999999, "t4_err_ovf");
    chk("t4_err_ovf_flag", 64'(bus.overflow), 64'd0);
    do_conv(32'h00000009, "t4_nine");

    // Start held high, inputs changing every cycle
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      words[k] = rand_word();
      set_bcd(words[k]);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_done", 64'(bus.done), 64'((k % 10) == 8));
      chk("t5_ready", 64'(bus.ready), 64'((k % 10) == 9));
      if ((k % 10) == 8) begin
        model(words[k-8], ebv, eof, ede);
        chk("t5_value", 64'(bus.binary_value), 64'(ebv));
        chk("t5_overflow", 64'(bus.overflow), 64'(eof));
        chk("t5_digit_error", 64'(bus.digit_error), 64'(ede));
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    // Make sure outputs are non-zero so the reset check is meaningful
    do_conv(32'h00012345, "t6_pre");

    // Abort by reset four cycles into a conversion
    @(negedge clk);
    set_bcd(32'h00000777);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    chk("t6_abort_value", 64'(bus.binary_value), 64'd0);
    chk("t6_abort_ready", 64'(bus.ready), 64'd1);
    chk("t6_abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("t6_no_done", 64'(pulses), 64'd0);

    // Round trip through a decimal encoding of random values
    for (int r = 0; r < 10; r++) begin
      v = $urandom_range(0, 67108863);
      do_conv(to_bcd(v), "t6_rt");
      chk("t6_roundtrip", 64'(bus.binary_value), 64'(v));
    end

    // Extra random patterns, including non-decimal digits
    for (int r = 0; r < 6; r++) do_conv(rand_word(), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
